clk_edge_gen: RTL and testbench
===============================

// Module: clk_edge_gen
// PURPOSE
//  Programmable, glitch-free clock/edge generator: drives clk_out with a 50%
//  duty waveform of half-period DIV clk cycles plus one-cycle rise/fall strobes.
//  Transmit-side counterpart of our clock edge detectors; it produces the edges
//  they detect. Used for slow peripheral clocks and bench stimulus.
//  Divide ratio changes use a valid/ready handshake and apply only on period
//  boundaries, so clk_out never emits a runt pulse.
// PARAMETERS
//  CNT_W        8   width of divide ratio and half-period counter
//  DEFAULT_DIV  4   half-period (clk cycles) after reset; 1..2^CNT_W-1
// PORTS
//  clk         in   1      system clock; all logic on posedge
//  rst         in   1      synchronous, active-high reset
//  en          in   1      run request; sampled at IDLE and at each LOW-phase end
//  div_in      in   CNT_W  requested half-period in clk cycles (0 treated as 1)
//  div_valid   in   1      div_in valid
//  div_ready   out  1      ratio slot free; transfer when div_valid & div_ready
//  clk_out     out  1      generated clock, registered
//  rise_pulse  out  1      high exactly in the first cycle clk_out==1 of a period
//  fall_pulse  out  1      high exactly in the first cycle clk_out==0 after HIGH
//  running     out  1      1 while state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, clk_out=0, rise/fall_pulse=0, running=0, div_act=DEFAULT_DIV,
//   pend_vld=0, div_ready=1. Reset mid-period forces these values next cycle, no
//   completion of the period.
//  Clamp: any accepted div_in==0 stored as 1. No other arithmetic; cnt is CNT_W bits.
//  States: IDLE, HIGH, LOW; cnt counts down.
//   IDLE: en=1 at edge t -> HIGH at t+1: clk_out=1, rise_pulse=1, cnt=div_act-1.
//   HIGH: cnt!=0 -> decrement. cnt==0 -> LOW: clk_out=0, fall_pulse=1, cnt=div_act-1.
//   LOW: cnt!=0 -> decrement. cnt==0 -> en=1: HIGH (as above); en=0: IDLE.
//  HIGH and LOW each last exactly div_act cycles; period = 2*div_act.
//  en drop mid-period: the period completes (full HIGH + full LOW), then IDLE with
//   clk_out=0. en is ignored everywhere except IDLE and LOW-end.
//  Ratio handshake: div_ready = ~pend_vld.
//   Accept in IDLE: div_act<=clamp(div_in) directly. pend_vld stays 0.
//   Accept in HIGH/LOW: pend<=clamp(div_in), pend_vld<=1.
//   On any transition into HIGH with registered pend_vld=1: div_act<=pend, pend_vld<=0,
//    cnt loads new value-1. The whole new period uses the new ratio.
//  Handshake in the same cycle as a HIGH entry goes to pend and applies next period.
//  fall_pulse never coincides with rise_pulse. Pulses only in the cycle clk_out changes.
//  DIV=1: clk_out toggles every cycle. rise/fall_pulse alternate every cycle.
//  div_valid with div_ready=0: ignored. The source holds the value until ready.
// TESTING
//  1 rst=1 3 cycles, en=0 -> clk_out=0, pulses 0, running=0, div_ready=1; stays idle.
//  2 DIV=4, en=1 held -> clk_out 4 high/4 low, rise_pulse every 8 cycles, first one
//    cycle after en; fall_pulse 4 cycles after each rise; 10 periods checked.
//  3 running DIV=4, send div_in=2 in the 2nd HIGH cycle -> div_ready=0 until next HIGH
//    entry; current period 4/4, following periods 2/2; second send stalls until ready.
//  4 en=0 in 1st HIGH cycle, DIV=3 -> 3 high + 3 low, then IDLE, clk_out=0, running=0;
//    en=1 in the final LOW cycle instead -> seamless next rise, no gap.
//  5 in IDLE send div_in=0 then en=1 -> period 2 (clamped to 1), pulses alternate.
//  6 rst=1 in mid HIGH -> next cycle clk_out=0, no fall_pulse, div_act=DEFAULT_DIV,
//    pending ratio discarded.

Source files
------------

// File: rtl/clk_edge_gen_if.sv
// Handshake and clock-output bundle of the programmable edge generator.
// The master side requests a run and supplies divide ratios; the slave side is the generator.
interface clk_edge_gen_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_valid;
    logic             div_ready;
    logic             clk_out;
    logic             rise_pulse;
    logic             fall_pulse;
    logic             running;

    modport master (
        output en,
        output div_in,
        output div_valid,
        input  div_ready,
        input  clk_out,
        input  rise_pulse,
        input  fall_pulse,
        input  running
    );

    modport slave (
        input  en,
        input  div_in,
        input  div_valid,
        output div_ready,
        output clk_out,
        output rise_pulse,
        output fall_pulse,
        output running
    );
endinterface

// File: rtl/clk_edge_gen.sv
// Glitch-free 50% duty clock generator with half-period of div_act clk cycles and
// one-cycle rise/fall strobes; ratio updates land only on period boundaries.
module clk_edge_gen #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input logic           clk,
    input logic           rst,
    clk_edge_gen_if.slave bus_io
);
    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] One    = CNT_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_act_q;
    logic [CNT_W-1:0] pend_q;
    logic             pend_vld_q;
    logic             clk_out_q;
    logic             rise_q;
    logic             fall_q;

    logic             accept;
    logic             cnt_zero;
    logic             enter_high;
    logic [CNT_W-1:0] div_clamped;
    logic [CNT_W-1:0] div_next;

    assign accept      = bus_io.div_valid & ~pend_vld_q;
    assign cnt_zero    = (cnt_q == '0);
    assign div_clamped = (bus_io.div_in == '0) ? One : bus_io.div_in;
    // en only matters in IDLE and at the last LOW cycle
    assign enter_high  = bus_io.en & ((state_q == StIdle) | ((state_q == StLow) & cnt_zero));
    assign div_next    = pend_vld_q ? pend_q : div_act_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_act_q  <= DefDiv;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_out_q  <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (enter_high) begin
                state_q    <= StHigh;
                clk_out_q  <= 1'b1;
                rise_q     <= 1'b1;
                cnt_q      <= div_next - One;
                div_act_q  <= div_next;
                pend_vld_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StHigh: begin
                        if (cnt_zero) begin
                            state_q   <= StLow;
                            clk_out_q <= 1'b0;
                            fall_q    <= 1'b1;
                            cnt_q     <= div_act_q - One;
                        end else begin
                            cnt_q <= cnt_q - One;
                        end
                    end
                    StLow: begin
                        if (cnt_zero) begin
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q - One;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
            // A ratio arriving on a HIGH entry edge waits for the following period
            if (accept) begin
                if ((state_q == StIdle) && !enter_high) begin
                    div_act_q <= div_clamped;
                end else begin
                    pend_q     <= div_clamped;
                    pend_vld_q <= 1'b1;
                end
            end
        end
    end

    assign bus_io.div_ready  = ~pend_vld_q;
    assign bus_io.clk_out    = clk_out_q;
    assign bus_io.rise_pulse = rise_q;
    assign bus_io.fall_pulse = fall_q;
    assign bus_io.running    = (state_q != StIdle);
endmodule

// File: tb/tb_clk_edge_gen.sv
// Directed bench for clk_edge_gen: reset, steady division, ratio handshake,
// en drop/restart, zero-clamp and mid-period reset.
module tb_clk_edge_gen;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    clk_edge_gen_if #(.CNT_W(8)) bus ();

    clk_edge_gen #(
        .CNT_W      (8),
        .DEFAULT_DIV(4)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wave(input string tag, input bit c, input bit r, input bit f);
        check({tag, ".clk_out"}, 32'(bus.clk_out), 32'(c));
        check({tag, ".rise"}, 32'(bus.rise_pulse), 32'(r));
        check({tag, ".fall"}, 32'(bus.fall_pulse), 32'(f));
    endtask

    // Current cycle must be the first HIGH cycle; leaves the bench at the next period start
    task automatic chk_period(input int div, input string tag);
        for (int i = 0; i < 2 * div; i++) begin
            chk_wave($sformatf("%s[%0d]", tag, i), i < div, i == 0, i == div);
            check($sformatf("%s[%0d].running", tag, i), 32'(bus.running), 32'd1);
            cyc();
        end
    endtask

    task automatic chk_idle(input string tag);
        chk_wave(tag, 1'b0, 1'b0, 1'b0);
        check({tag, ".running"}, 32'(bus.running), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.div_in    = '0;
        bus.div_valid = 1'b0;

        // 1: reset and idle
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_idle($sformatf("rst%0d", i));
            check($sformatf("rst%0d.ready", i), 32'(bus.div_ready), 32'd1);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk_idle($sformatf("idle%0d", i));
        end

        // 2: default DIV=4, ten periods
        bus.en = 1'b1;
        cyc();
        for (int p = 0; p < 10; p++) chk_period(4, $sformatf("div4p%0d", p));

        // 3: ratio change mid-period, second send stalls until the slot frees
        for (int i = 0; i < 8; i++) begin
            chk_wave($sformatf("chg4[%0d]", i), i < 4, i == 0, i == 4);
            if (i == 1) begin
                check("chg4.ready_before", 32'(bus.div_ready), 32'd1);
                bus.div_in    = 8'd2;
                bus.div_valid = 1'b1;
            end
            if (i == 2) bus.div_in = 8'd3;
            if (i >= 2) check($sformatf("chg4[%0d].ready", i), 32'(bus.div_ready), 32'd0);
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            chk_wave($sformatf("chg2[%0d]", i), i < 2, i == 0, i == 2);
            check($sformatf("chg2[%0d].ready", i), 32'(bus.div_ready), 32'(i == 0));
            if (i == 1) bus.div_valid = 1'b0;
            cyc();
        end
        check("chg3.ready", 32'(bus.div_ready), 32'd1);
        chk_period(3, "chg3");

        // 4: en drop in first HIGH cycle completes the period, then idles
        bus.en = 1'b0;
        chk_period(3, "drop3");
        chk_idle("drop_idle0");
        cyc();
        chk_idle("drop_idle1");
        bus.en = 1'b1;
        cyc();
        for (int i = 0; i < 6; i++) begin
            chk_wave($sformatf("reen[%0d]", i), i < 3, i == 0, i == 3);
            if (i == 0) bus.en = 1'b0;
            if (i == 5) bus.en = 1'b1;
            cyc();
        end
        chk_wave("seamless", 1'b1, 1'b1, 1'b0);
        check("seamless.running", 32'(bus.running), 32'd1);
        bus.en = 1'b0;
        chk_period(3, "tail3");
        chk_idle("tail_idle");

        // 5: zero ratio in IDLE clamps to 1
        bus.div_in    = 8'd0;
        bus.div_valid = 1'b1;
        check("clamp.ready", 32'(bus.div_ready), 32'd1);
        cyc();
        bus.div_valid = 1'b0;
        chk_idle("clamp_idle");
        bus.en = 1'b1;
        cyc();
        for (int p = 0; p < 3; p++) chk_period(1, $sformatf("div1p%0d", p));

        // 6: reset in mid HIGH discards the pending ratio
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk_idle("pre6_idle");
        bus.div_in    = 8'd5;
        bus.div_valid = 1'b1;
        cyc();
        bus.div_valid = 1'b0;
        bus.en        = 1'b1;
        cyc();
        chk_wave("div5_h0", 1'b1, 1'b1, 1'b0);
        cyc();
        bus.div_in    = 8'd7;
        bus.div_valid = 1'b1;
        cyc();
        check("div5.pend_ready", 32'(bus.div_ready), 32'd0);
        chk_wave("div5_h2", 1'b1, 1'b0, 1'b0);
        rst           = 1'b1;
        bus.div_valid = 1'b0;
        bus.en        = 1'b0;
        cyc();
        chk_idle("midrst");
        check("midrst.ready", 32'(bus.div_ready), 32'd1);
        rst    = 1'b0;
        bus.en = 1'b1;
        cyc();
        chk_period(4, "postrst4");
        bus.en = 1'b0;
        chk_period(4, "postrst4b");
        chk_idle("end_idle");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
